green_blend_ctrl: RTL and testbench
===================================

GREEN_BLEND_CTRL -- requirements
Module: green_blend_ctrl

Interface
REQ-001 The block SHALL have parameter pixelBitWidth, default 12, output pixel width.
REQ-002 The block SHALL have parameter weightBitWidth, default 8, unsigned weight width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  the operand set is valid.
REQ-006 The block SHALL have port in_ready  output  1  the block accepts an operand set this cycle.
REQ-007 The block SHALL have port green_s, green_f  input  pixelBitWidth+1 each  two's-complement green estimates.
REQ-008 The block SHALL have port w_s, w_f  input  weightBitWidth each  unsigned blend weights.
REQ-009 The block SHALL have port out_valid  output  1  green holds a valid result.
REQ-010 The block SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 The block SHALL have port green  output  pixelBitWidth  clamped blended pixel.
REQ-012 The block SHALL have port sat_lo, sat_hi  output  1 each  the current result was clamped to 0 or to max.
REQ-013 The block SHALL have port busy  output  1  the state is not IDLE.
REQ-014 The block SHALL have port sat_count  output  16  saturation event count (see Configuration).

Function
REQ-015 The block SHALL implement an FSM with states IDLE, MS, MF, SAT, HOLD, using one shared signed (pixelBitWidth+1)x(weightBitWidth+1) multiplier, time-multiplexed.
REQ-016 in_ready SHALL equal (state==IDLE) | (state==HOLD & out_ready); acceptance occurs when in_valid & in_ready.
REQ-017 On acceptance, the block SHALL latch green_s, green_f, w_s and w_f and go to MS; later input changes SHALL be ignored.
REQ-018 In MS, acc (pixelBitWidth+weightBitWidth+2 bits, signed) SHALL load green_s*w_s, with the weight zero-extended; the FSM then goes to MF.
REQ-019 In MF, acc SHALL load acc + green_f*w_f; the FSM then goes to SAT.
REQ-020 In SAT, the clamped value SHALL register into green: acc<0 -> 0 with sat_lo=1; acc>2^pixelBitWidth-1 -> 2^pixelBitWidth-1 with sat_hi=1; otherwise acc[pixelBitWidth-1:0] with both flags 0. out_valid SHALL be set and the FSM goes to HOLD.
REQ-021 Latency SHALL be out_valid high exactly 3 clocks after the acceptance edge.
REQ-022 In HOLD, green, sat_lo, sat_hi and out_valid SHALL stay stable until out_ready is high.
REQ-023 In HOLD with out_ready high and no acceptance, out_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-024 In HOLD with out_ready high and acceptance in the same cycle, out_valid SHALL clear and the FSM SHALL go to MS with the new operands (simultaneous handoff, no bubble lost).
REQ-025 Peak throughput SHALL be one pixel per 4 clocks.
REQ-026 in_valid while the FSM is in MS, MF or SAT SHALL be ignored (in_ready is low).
REQ-027 An exact sum of 2^pixelBitWidth-1 SHALL pass unclamped; a sum of 0 SHALL pass unclamped with sat_lo=0.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set state=IDLE, acc=0, green=0, out_valid=0, sat_lo=0, sat_hi=0, sat_count=0 and busy=0.
REQ-029 rst SHALL abort any in-flight pixel with no output produced; in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-030 With macro GREEN_SAT_COUNT_EN defined, sat_count SHALL increment on every SAT cycle where sat_lo|sat_hi is being set, saturating at 65535 (no wrap).
REQ-031 Without GREEN_SAT_COUNT_EN, sat_count SHALL be driven constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-032 Scenario: green_s=1000, w_s=2, green_f=500, w_f=3 -> green=3500, sat flags 0, out_valid 3 clocks after accept.
REQ-033 Scenario: green_s=4000, w_s=255, green_f=0, w_f=0 -> green=4095, sat_hi=1, sat_count=1 (macro on) or 0 (macro off).
REQ-034 Scenario: green_s=-100 (13'h1F9C), w_s=10, green_f=50, w_f=10 -> sum -500, green=0, sat_lo=1.
REQ-035 Scenario: boundary inputs green_s=4095, w_s=1, then green_f=0 -> 4095 with sat_hi=0; then green_f=1, w_f=1 -> 4095 with sat_hi=1.
REQ-036 Scenario: out_ready low 5 cycles while in_valid is held -> green stable and in_ready=0; out_ready rises -> same-cycle accept, next result 3 clocks later.
REQ-037 Scenario: rst pulsed while in MF -> next cycle out_valid=0, green=0, sat_count=0, in_ready=1, and no result is emitted.

Source files
------------

// File: rtl/green_blend_ctrl_if.sv
// ============================================================================
//  Module   : green_blend_ctrl_if
//  Purpose  : Operand/result handshake bundle for green_blend_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface green_blend_ctrl_if #(
    parameter int pixelBitWidth  = 12,
    parameter int weightBitWidth = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic signed [pixelBitWidth:0]    green_s;
    logic signed [pixelBitWidth:0]    green_f;
    logic        [weightBitWidth-1:0] w_s;
    logic        [weightBitWidth-1:0] w_f;
    logic                             out_valid;
    logic                             out_ready;
    logic        [pixelBitWidth-1:0]  green;
    logic                             sat_lo;
    logic                             sat_hi;
    logic                             busy;
    logic        [15:0]               sat_count;

    modport master (
        output in_valid, green_s, green_f, w_s, w_f, out_ready,
        input  in_ready, out_valid, green, sat_lo, sat_hi, busy, sat_count
    );

    modport slave (
        input  in_valid, green_s, green_f, w_s, w_f, out_ready,
        output in_ready, out_valid, green, sat_lo, sat_hi, busy, sat_count
    );
endinterface

`default_nettype wire

// File: rtl/green_blend_ctrl.sv
// ============================================================================
//  Module   : green_blend_ctrl
//  Purpose  : Weighted blend of two green estimates with a shared multiplier,
//             clamped to [0, 2^pixelBitWidth-1]. Optional macro
//             GREEN_SAT_COUNT_EN enables the saturation event counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module green_blend_ctrl #(
    parameter int pixelBitWidth  = 12,
    parameter int weightBitWidth = 8
) (
    input  logic              clk,
    input  logic              rst,
    green_blend_ctrl_if.slave bus
);
    localparam int ACC_W = pixelBitWidth + weightBitWidth + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MS   = 3'd1,
        S_MF   = 3'd2,
        S_SAT  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t                           r_state;
    state_t                           w_next;
    logic signed [pixelBitWidth:0]    r_green_s;
    logic signed [pixelBitWidth:0]    r_green_f;
    logic        [weightBitWidth-1:0] r_w_s;
    logic        [weightBitWidth-1:0] r_w_f;
    logic signed [ACC_W-1:0]          r_acc;
    logic        [pixelBitWidth-1:0]  r_green;
    logic                             r_out_valid;
    logic                             r_sat_lo;
    logic                             r_sat_hi;

    logic                             w_in_ready;
    logic                             w_accept;
    logic signed [pixelBitWidth:0]    w_mul_a;
    logic signed [weightBitWidth:0]   w_mul_b;
    logic signed [ACC_W-1:0]          w_prod;
    logic                             w_neg;
    logic                             w_over;
    logic        [pixelBitWidth-1:0]  w_clamped;

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus multiplier operand select: MS uses the s-pair, MF the f-pair.
    always_comb begin
        w_next  = r_state;
        w_mul_a = r_green_s;
        w_mul_b = $signed({1'b0, r_w_s});
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_MS;
            S_MS:   w_next = S_MF;
            S_MF: begin
                w_next  = S_SAT;
                w_mul_a = r_green_f;
                w_mul_b = $signed({1'b0, r_w_f});
            end
            S_SAT:  w_next = S_HOLD;
            S_HOLD: begin
                if (w_accept) begin
                    w_next = S_MS;
                end else if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_prod    = ACC_W'(w_mul_a) * ACC_W'(w_mul_b);
    assign w_neg     = r_acc[ACC_W-1];
    assign w_over    = !w_neg && (|r_acc[ACC_W-2:pixelBitWidth]);
    assign w_clamped = w_neg ? '0 : (w_over ? '1 : r_acc[pixelBitWidth-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_green_s   <= '0;
            r_green_f   <= '0;
            r_w_s       <= '0;
            r_w_f       <= '0;
            r_acc       <= '0;
            r_green     <= '0;
            r_out_valid <= 1'b0;
            r_sat_lo    <= 1'b0;
            r_sat_hi    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_green_s <= bus.green_s;
                r_green_f <= bus.green_f;
                r_w_s     <= bus.w_s;
                r_w_f     <= bus.w_f;
            end
            case (r_state)
                S_MS:  r_acc <= w_prod;
                S_MF:  r_acc <= r_acc + w_prod;
                S_SAT: begin
                    r_green     <= w_clamped;
                    r_sat_lo    <= w_neg;
                    r_sat_hi    <= w_over;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: if (bus.out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef GREEN_SAT_COUNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= 16'd0;
        end else if ((r_state == S_SAT) && (w_neg || w_over) && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign bus.sat_count = r_sat_count;
`else
    assign bus.sat_count = 16'd0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.green     = r_green;
    assign bus.sat_lo    = r_sat_lo;
    assign bus.sat_hi    = r_sat_hi;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_green_blend_ctrl.sv
// ============================================================================
//  Module   : tb_green_blend_ctrl
//  Purpose  : Directed-vector scoreboard bench for green_blend_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_green_blend_ctrl;
    localparam int PW = 12;
    localparam int WW = 8;

    typedef struct {
        logic [PW-1:0] green;
        logic          lo;
        logic          hi;
        logic [15:0]   cnt;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    bit   shown   = 1'b0;

    green_blend_ctrl_if #(.pixelBitWidth(PW), .weightBitWidth(WW)) bus ();

    green_blend_ctrl #(.pixelBitWidth(PW), .weightBitWidth(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int eg, input bit lo, input bit hi);
        exp_t e;
`ifdef GREEN_SAT_COUNT_EN
        if ((lo || hi) && exp_cnt < 65535) exp_cnt++;
`endif
        e.green   = PW'(eg);
        e.lo      = lo;
        e.hi      = hi;
        e.cnt     = 16'(exp_cnt);
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic set_ops(input int gs, input int ws, input int gf, input int wf);
        bus.green_s = 13'(gs);
        bus.w_s     = 8'(ws);
        bus.green_f = 13'(gf);
        bus.w_f     = 8'(wf);
    endtask

    task automatic send(input int gs, input int ws, input int gf, input int wf,
                        input int eg, input bit lo, input bit hi);
        int t;
        set_ops(gs, ws, gf, wf);
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        push_exp(eg, lo, hi);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output handshake, checks latency on first sight.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", bus.out_valid, 0);
            end else begin
                if (!shown) begin
                    check("latency", cyc - sb[0].acc_cyc, 3);
                    shown = 1'b1;
                end
                if (bus.out_ready) begin
                    mon_e = sb.pop_front();
                    check("green", bus.green, mon_e.green);
                    check("sat_lo", bus.sat_lo, mon_e.lo);
                    check("sat_hi", bus.sat_hi, mon_e.hi);
                    check("sat_count", bus.sat_count, mon_e.cnt);
                    shown = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_ops(0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_green", bus.green, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sat_count", bus.sat_count, 0);
        @(posedge clk);
        #1;

        send(1000, 2, 500, 3, 3500, 0, 0);         drain();
        send(4000, 255, 0, 0, 4095, 0, 1);         drain();
        send(-100, 10, 50, 10, 0, 1, 0);           drain();
        send(4095, 1, 0, 0, 4095, 0, 0);           drain();
        send(4095, 1, 1, 1, 4095, 0, 1);           drain();
        send(0, 200, 0, 100, 0, 0, 0);             drain();
        send(2000, 3, -1000, 2, 4000, 0, 0);       drain();
        send(-4096, 255, -4096, 255, 0, 1, 0);     drain();
        send(10, 1, 20, 1, 30, 0, 0);
        send(40, 1, 50, 1, 90, 0, 0);              drain();

        // Consumer stalls while the next operand set waits at the input.
        bus.out_ready = 1'b0;
        send(100, 1, 200, 1, 300, 0, 0);
        set_ops(10, 10, 20, 20);
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("hold_green", bus.green, 300);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_busy", bus.busy, 1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("handoff_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        push_exp(500, 0, 0);
        drain();

        // Reset lands while the FSM sits in MF.
        send(1000, 2, 500, 3, 3500, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb.pop_back());
        exp_cnt = 0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_green", bus.green, 0);
        check("abort_sat_count", bus.sat_count, 0);
        check("abort_in_ready", bus.in_ready, 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        send(1, 1, 1, 1, 2, 0, 0);                 drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
